// File: rtl/reg_file_re_ar_pkg.sv
// reg_file_re_ar_pkg
//   Shared constants and helpers for the register file slice.
//   - DEFAULT_WIDTH / DEFAULT_DEPTH / DEFAULT_RST_VAL : default geometry and reset word
//   - clog2(value)      : ceiling log2, 0 for value <= 1
//   - addr_width(depth) : address bits needed for depth words, never less than 1
package reg_file_re_ar_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_RST_VAL = 0;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // A single-word address still needs one wire.
  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_re_ar_if.sv
// reg_file_re_ar_if
//   Write/read bus of the register file.
//   master : decode side, drives clr, we, waddr, wdata, raddr_a, raddr_b
//            and receives rdata_a, rdata_b
//   slave  : the register file itself
interface reg_file_re_ar_if
  import reg_file_re_ar_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = addr_width(DEFAULT_DEPTH)
);

  logic             clr;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;

  modport master (
    output clr, we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b
  );

  modport slave (
    input  clr, we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b
  );

endinterface

// File: rtl/reg_file_re_ar_word.sv
// reg_file_re_ar_word
//   One WIDTH-bit storage word, rising-edge clocked.
//   clk : clock
//   rst : asynchronous active-high reset, loads RST_VAL
//   clr : synchronous clear, loads RST_VAL
//   en  : load d on the edge
//   d   : write data
//   q   : stored value
//   Priority rst > clr > en.
module reg_file_re_ar_word
  import reg_file_re_ar_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_re_ar.sv
// reg_file_re_ar
//   Architectural register file: DEPTH words of WIDTH bits, two combinational
//   read ports, one write port, synchronous clear, optional write-to-read bypass.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset, every word loads RST_VAL
//   bus : slave side of reg_file_re_ar_if (clr, we, waddr, wdata,
//         raddr_a/rdata_a, raddr_b/rdata_b)
//   ZERO_REG=1 hard-wires word 0 to zero; BYPASS=1 forwards a legal
//   same-cycle write to any read port addressing the written word.
module reg_file_re_ar
  import reg_file_re_ar_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               DEPTH    = DEFAULT_DEPTH,
  parameter bit               ZERO_REG = 1'b1,
  parameter bit               BYPASS   = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = WIDTH'(DEFAULT_RST_VAL)
) (
  input logic              clk,
  input logic              rst,
  reg_file_re_ar_if.slave  bus
);

  localparam int AW = addr_width(DEPTH);

  logic [WIDTH-1:0] words [DEPTH];
  logic             write_legal;
  logic             bypass_a;
  logic             bypass_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;

  // Out-of-range addresses and the hard-wired zero word never accept data.
  assign write_legal = bus.we && (32'(bus.waddr) < DEPTH) &&
                       !(ZERO_REG && (bus.waddr == '0));

  // Forwarding must not show data that the coming edge will not store,
  // so clear and reset both suppress it.
  assign bypass_a = BYPASS && write_legal && !bus.clr && !rst && (bus.waddr == bus.raddr_a);
  assign bypass_b = BYPASS && write_legal && !bus.clr && !rst && (bus.waddr == bus.raddr_b);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG && i == 0) begin : g_zero
      assign words[i] = '0;
    end else begin : g_reg
      logic en;
      assign en = write_legal && (bus.waddr == AW'(i));
      reg_file_re_ar_word #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_word (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .en  (en),
        .d   (bus.wdata),
        .q   (words[i])
      );
    end
  end

  // Addresses past the last word read as zero so the ports never go X.
  always_comb begin
    rdata_a = '0;
    if (32'(bus.raddr_a) < DEPTH) begin
      rdata_a = words[bus.raddr_a];
    end
    if (bypass_a) begin
      rdata_a = bus.wdata;
    end
  end

  always_comb begin
    rdata_b = '0;
    if (32'(bus.raddr_b) < DEPTH) begin
      rdata_b = words[bus.raddr_b];
    end
    if (bypass_b) begin
      rdata_b = bus.wdata;
    end
  end

  assign bus.rdata_a = rdata_a;
  assign bus.rdata_b = rdata_b;

endmodule

// File: tb/tb_reg_file_re_ar.sv
// tb_reg_file_re_ar
//   Drives two register files with identical stimulus:
//   dut_m : WIDTH 8, DEPTH 8, ZERO_REG 1, BYPASS 1, RST_VAL 8'h00
//   dut_n : WIDTH 8, DEPTH 6, ZERO_REG 0, BYPASS 0, RST_VAL 8'h5A
//   Inputs change 1 ns after a rising edge; outputs are compared on the
//   falling edge, so same-cycle forwarding is visible before the edge commits.
module tb_reg_file_re_ar;

  logic clk;
  logic rst;

  reg_file_re_ar_if #(.WIDTH(8), .AW(3)) bus_m ();
  reg_file_re_ar_if #(.WIDTH(8), .AW(3)) bus_n ();

  reg_file_re_ar #(
    .WIDTH    (8),
    .DEPTH    (8),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1),
    .RST_VAL  (8'h00)
  ) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  reg_file_re_ar #(
    .WIDTH    (8),
    .DEPTH    (6),
    .ZERO_REG (1'b0),
    .BYPASS   (1'b0),
    .RST_VAL  (8'h5A)
  ) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] n_a;
    logic [7:0] n_b;
  } vec_t;

  vec_t vecs [16];
  int   checks;
  int   passes;

  task automatic applyStimulus(input logic clr, input logic we, input logic [2:0] waddr,
                               input logic [7:0] wdata, input logic [2:0] raddr_a,
                               input logic [2:0] raddr_b);
    bus_m.clr = clr;  bus_n.clr = clr;
    bus_m.we = we;    bus_n.we = we;
    bus_m.waddr = waddr;  bus_n.waddr = waddr;
    bus_m.wdata = wdata;  bus_n.wdata = wdata;
    bus_m.raddr_a = raddr_a;  bus_n.raddr_a = raddr_a;
    bus_m.raddr_b = raddr_b;  bus_n.raddr_b = raddr_b;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end else begin
      passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;

    // clr we wa wdata ra rb | m_a m_b | n_a n_b
    vecs[0]  = '{1'b0, 1'b1, 3'd3, 8'hA5, 3'd3, 3'd2, 8'hA5, 8'h00, 8'h5A, 8'h5A};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd2, 8'hA5, 8'h00, 8'hA5, 8'h5A};
    vecs[2]  = '{1'b0, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 8'h3C, 8'h3C, 8'h5A, 8'h5A};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[4]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 8'h00, 8'h00, 8'h5A, 8'h5A};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 8'h00, 8'h3C, 8'hFF, 8'h3C};
    vecs[6]  = '{1'b0, 1'b1, 3'd7, 8'h77, 3'd7, 3'd6, 8'h77, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 8'h77, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 3'd6, 8'h66, 3'd6, 3'd1, 8'h66, 8'h00, 8'h00, 8'h5A};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd1, 8'h66, 8'h00, 8'h00, 8'h5A};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd2, 8'h00, 8'h00, 8'h5A, 8'h5A};
    vecs[11] = '{1'b1, 1'b1, 3'd4, 8'h11, 3'd4, 3'd3, 8'h00, 8'hA5, 8'h5A, 8'hA5};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd3, 8'h00, 8'h00, 8'h5A, 8'h5A};
    vecs[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 8'h00, 8'h00, 8'h5A, 8'h5A};
    vecs[14] = '{1'b0, 1'b1, 3'd2, 8'hC3, 3'd2, 3'd4, 8'hC3, 8'h00, 8'h5A, 8'h5A};
    vecs[15] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'hC3, 8'hC3, 8'hC3, 8'hC3};

    // Reset held over two edges with random traffic on the bus.
    rst = 1'b1;
    applyStimulus(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
                  3'($urandom), 3'($urandom));
    repeat (2) begin
      @(posedge clk);
      #1;
      applyStimulus(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
                    3'($urandom), 3'($urandom));
    end
    for (int a = 0; a < 8; a++) begin
      #1;
      applyStimulus(1'($urandom), 1'b1, 3'(a), 8'($urandom), 3'(a), 3'(7 - a));
      #1;
      checkOutput($sformatf("rst_m_a%0d", a), bus_m.rdata_a, 8'h00);
      checkOutput($sformatf("rst_n_a%0d", a), bus_n.rdata_a, (a < 6) ? 8'h5A : 8'h00);
      checkOutput($sformatf("rst_n_b%0d", a), bus_n.rdata_b, (7 - a < 6) ? 8'h5A : 8'h00);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i].clr, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                    vecs[i].raddr_a, vecs[i].raddr_b);
      @(negedge clk);
      checkOutput($sformatf("v%0d_m_a", i), bus_m.rdata_a, vecs[i].m_a);
      checkOutput($sformatf("v%0d_m_b", i), bus_m.rdata_b, vecs[i].m_b);
      checkOutput($sformatf("v%0d_n_a", i), bus_n.rdata_a, vecs[i].n_a);
      checkOutput($sformatf("v%0d_n_b", i), bus_n.rdata_b, vecs[i].n_b);
    end

    // Reset raised mid-cycle after a write was set up: word 2 clears at once,
    // forwarding stops and the pending write to word 1 is lost.
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 3'd1, 8'h99, 3'd2, 3'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_m_a", bus_m.rdata_a, 8'h00);
    checkOutput("midrst_m_b", bus_m.rdata_b, 8'h00);
    checkOutput("midrst_n_a", bus_n.rdata_a, 8'h5A);
    checkOutput("midrst_n_b", bus_n.rdata_b, 8'h5A);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_m_a", bus_m.rdata_a, 8'h00);
    checkOutput("postrst_n_a", bus_n.rdata_a, 8'h5A);
    checkOutput("postrst_n_b", bus_n.rdata_b, 8'h5A);

    // First write after reset release lands normally.
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 3'd4, 8'h42, 3'd1, 3'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd1);
    @(negedge clk);
    checkOutput("relwr_m_a", bus_m.rdata_a, 8'h42);
    checkOutput("relwr_n_a", bus_n.rdata_a, 8'h42);
    checkOutput("relwr_n_b", bus_n.rdata_b, 8'h5A);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
